// File: rtl/ctrl_pkg.sv
// Shared definitions for the registered control pipeline: opcodes, control
// field encodings, the decoded control bundle and the mul/div busy states.
package ctrl_pkg;

  // Base opcodes (instr[6:0]) recognised by the decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // One-hot immediate selector
  localparam logic [5:0] EXT_NONE    = 6'b000000;
  localparam logic [5:0] EXT_I_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I       = 6'b010000;
  localparam logic [5:0] EXT_S       = 6'b001000;
  localparam logic [5:0] EXT_B       = 6'b000100;
  localparam logic [5:0] EXT_U       = 6'b000010;
  localparam logic [5:0] EXT_J       = 6'b000001;

  // Next-PC source
  localparam logic [2:0] NPC_PC4    = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JAL    = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  // Register-file write-back source
  localparam logic [1:0] RFW_FROM_ALU = 2'b00;
  localparam logic [1:0] RFW_FROM_MEM = 2'b01;
  localparam logic [1:0] RFW_FROM_PC4 = 2'b10;
  localparam logic [1:0] RFW_FROM_MD  = 2'b11;

  // funct7 patterns that select base, alternate (sub/sra) and RV32M ops
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Fixed ALU codes for the upper-immediate instructions
  localparam logic [4:0] ALU_LUI   = 5'b11001;
  localparam logic [4:0] ALU_AUIPC = 5'b11010;

  // Busy sequencer for the shared multi-cycle mul/div unit
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Everything EX needs, produced by the decoder and held in the pipe register
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [5:0] ext_op;
    logic [2:0] npc_op;
    logic       alu_src;
    logic [4:0] alu_op;
    logic       dm_we;
    logic       dm_re;
    logic       dm_sign;
    logic [1:0] dm_width;
    logic       rf_we;
    logic [1:0] rf_wsrc;
    logic       md_en;
    logic [2:0] md_op;
    logic       illegal;
  } ctrl_bundle_t;

  // Larger of two integers, used to size the busy counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Handshake and control-bundle bus between IF/ID, the control pipe and EX.
// The master side feeds instructions and accepts bundles; the slave is the pipe.
interface ctrl_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [5:0]  ext_op;
  logic [2:0]  npc_op;
  logic        alu_src;
  logic [4:0]  alu_op;
  logic        dm_we;
  logic        dm_re;
  logic        dm_sign;
  logic [1:0]  dm_width;
  logic        rf_we;
  logic [1:0]  rf_wsrc;
  logic        md_en;
  logic [2:0]  md_op;
  logic        illegal;

  modport master (
    output in_valid, instr, pc_in, flush, out_ready,
    input  in_ready, out_valid, pc_out, rd, rs1, rs2, ext_op, npc_op,
           alu_src, alu_op, dm_we, dm_re, dm_sign, dm_width, rf_we,
           rf_wsrc, md_en, md_op, illegal
  );

  modport slave (
    input  in_valid, instr, pc_in, flush, out_ready,
    output in_ready, out_valid, pc_out, rd, rs1, rs2, ext_op, npc_op,
           alu_src, alu_op, dm_we, dm_re, dm_sign, dm_width, rf_we,
           rf_wsrc, md_en, md_op, illegal
  );
endinterface

// File: rtl/ctrl_pipe_decode.sv
// Pure combinational RV32I(+M) decoder: instruction word in, control bundle
// out. Unsupported encodings raise illegal and have all side effects cleared.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Decode the opcode into control fields, then squash side effects if illegal
  always_comb begin
    bundle     = '0;
    bad        = 1'b0;
    bundle.rd  = instr[11:7];
    bundle.rs1 = instr[19:15];
    bundle.rs2 = instr[24:20];

    case (opcode)
      OP_R: begin
        bundle.rf_we = 1'b1;
        if (funct7 == F7_MULDIV) begin
          if (EN_M) begin
            bundle.md_en   = 1'b1;
            bundle.md_op   = funct3;
            bundle.rf_wsrc = RFW_FROM_MD;
          end else begin
            bad = 1'b1;
          end
        end else if (funct7 == F7_BASE) begin
          bundle.alu_op = {2'b00, funct3};
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          bundle.alu_op = {2'b01, funct3};
        end else begin
          bad = 1'b1;
        end
      end

      OP_I_ALU: begin
        bundle.rf_we   = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.ext_op  = EXT_I;
        bundle.alu_op  = {2'b00, funct3};
        if (funct3 == 3'b001) begin
          bundle.ext_op = EXT_I_SHAMT;
          if (funct7 != F7_BASE) bad = 1'b1;
        end else if (funct3 == 3'b101) begin
          bundle.ext_op = EXT_I_SHAMT;
          if (funct7 == F7_ALT) begin
            bundle.alu_op = {2'b01, funct3};
          end else if (funct7 != F7_BASE) begin
            bad = 1'b1;
          end
        end
      end

      OP_LOAD: begin
        bundle.rf_we    = 1'b1;
        bundle.rf_wsrc  = RFW_FROM_MEM;
        bundle.alu_src  = 1'b1;
        bundle.ext_op   = EXT_I;
        bundle.dm_re    = 1'b1;
        bundle.dm_sign  = ~funct3[2];
        bundle.dm_width = funct3[1:0];
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) bad = 1'b1;
      end

      OP_STORE: begin
        bundle.alu_src  = 1'b1;
        bundle.ext_op   = EXT_S;
        bundle.dm_we    = 1'b1;
        bundle.dm_width = funct3[1:0];
        if (funct3[2] || funct3 == 3'b011) bad = 1'b1;
      end

      OP_BRANCH: begin
        bundle.ext_op = EXT_B;
        bundle.npc_op = NPC_BRANCH;
        bundle.alu_op = {2'b10, funct3};
        if (funct3[2:1] == 2'b01) bad = 1'b1;
      end

      OP_JAL: begin
        bundle.ext_op  = EXT_J;
        bundle.npc_op  = NPC_JAL;
        bundle.rf_we   = 1'b1;
        bundle.rf_wsrc = RFW_FROM_PC4;
      end

      OP_JALR: begin
        bundle.ext_op  = EXT_I;
        bundle.npc_op  = NPC_JALR;
        bundle.alu_src = 1'b1;
        bundle.rf_we   = 1'b1;
        bundle.rf_wsrc = RFW_FROM_PC4;
        if (funct3 != 3'b000) bad = 1'b1;
      end

      OP_LUI: begin
        bundle.ext_op  = EXT_U;
        bundle.alu_src = 1'b1;
        bundle.rf_we   = 1'b1;
        bundle.alu_op  = ALU_LUI;
      end

      OP_AUIPC: begin
        bundle.ext_op  = EXT_U;
        bundle.alu_src = 1'b1;
        bundle.rf_we   = 1'b1;
        bundle.alu_op  = ALU_AUIPC;
      end

      default: bad = 1'b1;
    endcase

    if (bad) begin
      bundle.rf_we  = 1'b0;
      bundle.dm_we  = 1'b0;
      bundle.dm_re  = 1'b0;
      bundle.npc_op = NPC_PC4;
      bundle.md_en  = 1'b0;
    end
    bundle.illegal = bad;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Registered control stage between IF/ID and EX: decodes into a valid/ready
// pipeline register, supports flush, and holds issue while the shared
// multi-cycle mul/div unit is busy.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter bit EN_M       = 1'b1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input logic          clk,
  input logic          rst,
  ctrl_pipe_if.slave   bus
);

  localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  ctrl_bundle_t    dec_bundle;
  ctrl_bundle_t    bundle_q;
  logic [31:0]     pc_q;
  logic            vld_q;
  md_state_t       state_q;
  md_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic            out_valid_c;
  logic            in_ready_c;
  logic            accept;
  logic            fire;

  ctrl_decode #(
    .EN_M (EN_M)
  ) u_decode (
    .instr  (bus.instr),
    .bundle (dec_bundle)
  );

  assign accept = bus.in_valid && in_ready_c;
  assign fire   = out_valid_c && bus.out_ready;

  // Pipeline register: flush wins over a same-cycle accept, accept wins over drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
    end else begin
      if (bus.flush) begin
        vld_q <= 1'b0;
      end else if (accept) begin
        vld_q <= 1'b1;
      end else if (fire) begin
        vld_q <= 1'b0;
      end
      if (accept && !bus.flush) begin
        bundle_q <= dec_bundle;
        pc_q     <= bus.pc_in;
      end
    end
  end

  // Busy FSM state register; an issued M op is never cancelled by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Busy FSM next state: enter on an issued M op, leave once the counter is spent
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (fire && bundle_q.md_en) state_d = MD_BUSY;
      MD_BUSY: if (cnt_q == '0) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Remaining busy cycles: loaded on issue (div if md_op[2]), counted down while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == MD_IDLE) begin
      if (fire && bundle_q.md_en) begin
        cnt_q <= bundle_q.md_op[2] ? DIV_LOAD : MUL_LOAD;
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Busy FSM outputs: hide the held bundle and block refill while busy
  always_comb begin
    out_valid_c = vld_q && (state_q == MD_IDLE);
    in_ready_c  = !vld_q || (bus.out_ready && (state_q == MD_IDLE));
  end

  assign bus.out_valid = out_valid_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.pc_out    = pc_q;
  assign bus.rd        = bundle_q.rd;
  assign bus.rs1       = bundle_q.rs1;
  assign bus.rs2       = bundle_q.rs2;
  assign bus.ext_op    = bundle_q.ext_op;
  assign bus.npc_op    = bundle_q.npc_op;
  assign bus.alu_src   = bundle_q.alu_src;
  assign bus.alu_op    = bundle_q.alu_op;
  assign bus.dm_we     = bundle_q.dm_we;
  assign bus.dm_re     = bundle_q.dm_re;
  assign bus.dm_sign   = bundle_q.dm_sign;
  assign bus.dm_width  = bundle_q.dm_width;
  assign bus.rf_we     = bundle_q.rf_we;
  assign bus.rf_wsrc   = bundle_q.rf_wsrc;
  assign bus.md_en     = bundle_q.md_en;
  assign bus.md_op     = bundle_q.md_op;
  assign bus.illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed testbench for ctrl_pipe: one RV32M-enabled instance for most
// scenarios and one with RV32M disabled for the illegal-M check.
module tb_ctrl_pipe;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SLL  = 32'h002091B3;
  localparam logic [31:0] I_LW   = 32'h00812283;
  localparam logic [31:0] I_DIV  = 32'h0220C1B3;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_JAL  = 32'h0080006F;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  ctrl_pipe_if bus ();
  ctrl_pipe_if bus_n ();

  ctrl_pipe #(.EN_M(1'b1), .MUL_CYCLES(4), .DIV_CYCLES(33)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ctrl_pipe #(.EN_M(1'b0), .MUL_CYCLES(4), .DIV_CYCLES(33)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  always #5 clk = ~clk;

  // Decode table: instr -> {illegal, alu_op, ext_op, npc_op}
  logic [31:0] dec_instr [5] = '{32'h4020D193, 32'h00208463, 32'h123450B7, 32'h00000097, 32'h000080E7};
  logic [14:0] dec_exp   [5] = '{{1'b0, 5'b01101, 6'b100000, 3'b000},
                                 {1'b0, 5'b10000, 6'b000100, 3'b001},
                                 {1'b0, 5'b11001, 6'b000010, 3'b000},
                                 {1'b0, 5'b11010, 6'b000010, 3'b000},
                                 {1'b0, 5'b00000, 6'b010000, 3'b100}};

  // Illegal encodings: bad srai funct7, unknown opcode, sll with alt funct7, jalr funct3!=0
  logic [31:0] ill_instr [4] = '{32'h4220D193, 32'h0000007F, 32'h402091B3, 32'h000090E7};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc_out: got %h want 0", bus.pc_out); end
    n_checks++; if ({bus.rd, bus.alu_op, bus.rf_we, bus.illegal, bus.md_en} !== 13'd0) begin
      n_fail++; $display("[TB] FAIL reset_bundle: got rd=%0d alu=%b we=%b ill=%b md=%b want all 0", bus.rd, bus.alu_op, bus.rf_we, bus.illegal, bus.md_en);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = I_ADD;
    bus.pc_in     = 32'h100;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL add_in_ready: got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL add_out_valid: got %b want 1", bus.out_valid); end
    n_checks++; if ({bus.alu_op, bus.rf_we, bus.rf_wsrc, bus.rd, bus.illegal} !== {5'b00000, 1'b1, 2'b00, 5'd3, 1'b0}) begin
      n_fail++; $display("[TB] FAIL add_bundle: got alu=%b we=%b wsrc=%b rd=%0d ill=%b want 00000 1 00 3 0", bus.alu_op, bus.rf_we, bus.rf_wsrc, bus.rd, bus.illegal);
    end
    n_checks++; if ({bus.rs1, bus.rs2, bus.pc_out} !== {5'd1, 5'd2, 32'h100}) begin
      n_fail++; $display("[TB] FAIL add_regs_pc: got rs1=%0d rs2=%0d pc=%h want 1 2 100", bus.rs1, bus.rs2, bus.pc_out);
    end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL add_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = I_SUB;
    step();
    bus.instr = I_SLL;
    #1;
    n_checks++; if ({bus.out_valid, bus.in_ready, bus.alu_op} !== {1'b1, 1'b1, 5'b01000}) begin
      n_fail++; $display("[TB] FAIL b2b_sub: got v=%b rdy=%b alu=%b want 1 1 01000", bus.out_valid, bus.in_ready, bus.alu_op);
    end
    step();
    bus.in_valid = 1'b0;
    n_checks++; if ({bus.out_valid, bus.alu_op} !== {1'b1, 5'b00001}) begin
      n_fail++; $display("[TB] FAIL b2b_sll: got v=%b alu=%b want 1 00001", bus.out_valid, bus.alu_op);
    end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = I_LW;
    bus.pc_in     = 32'h300;
    step();
    bus.instr = I_ADD;
    bus.pc_in = 32'h304;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if ({bus.out_valid, bus.in_ready, bus.dm_re, bus.rf_wsrc, bus.ext_op, bus.rd, bus.dm_sign, bus.dm_width} !==
                      {1'b1, 1'b0, 1'b1, 2'b01, 6'b010000, 5'd5, 1'b1, 2'b10}) begin
        n_fail++; $display("[TB] FAIL stall_hold_%0d: got v=%b rdy=%b re=%b wsrc=%b ext=%b rd=%0d sign=%b w=%b want 1 0 1 01 010000 5 1 10",
                           k, bus.out_valid, bus.in_ready, bus.dm_re, bus.rf_wsrc, bus.ext_op, bus.rd, bus.dm_sign, bus.dm_width);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if ({bus.in_ready, bus.pc_out} !== {1'b1, 32'h300}) begin
      n_fail++; $display("[TB] FAIL stall_release: got rdy=%b pc=%h want 1 300", bus.in_ready, bus.pc_out);
    end
    step();
    bus.in_valid = 1'b0;
    n_checks++; if ({bus.out_valid, bus.rd, bus.dm_re, bus.pc_out} !== {1'b1, 5'd3, 1'b0, 32'h304}) begin
      n_fail++; $display("[TB] FAIL stall_next: got v=%b rd=%0d re=%b pc=%h want 1 3 0 304", bus.out_valid, bus.rd, bus.dm_re, bus.pc_out);
    end
    step();
  endtask

  task automatic test_md_latency(input logic [31:0] op, input int want, input string name);
    int stall;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = op;
    bus.pc_in     = 32'h200;
    step();
    bus.instr = I_ADD;
    bus.pc_in = 32'h204;
    #1;
    n_checks++; if ({bus.out_valid, bus.md_en, bus.rf_wsrc, bus.alu_op, bus.md_op, bus.illegal} !== {1'b1, 1'b1, 2'b11, 5'b00000, op[14:12], 1'b0}) begin
      n_fail++; $display("[TB] FAIL %s_issue: got v=%b md=%b wsrc=%b alu=%b mdop=%b ill=%b want 1 1 11 00000 %b 0",
                         name, bus.out_valid, bus.md_en, bus.rf_wsrc, bus.alu_op, bus.md_op, bus.illegal, op[14:12]);
    end
    step();
    bus.in_valid = 1'b0;
    stall = 0;
    while (bus.out_valid !== 1'b1 && stall < 100) begin
      stall++;
      step();
    end
    n_checks++; if (stall != want) begin n_fail++; $display("[TB] FAIL %s_busy_cycles: got %0d want %0d", name, stall, want); end
    n_checks++; if ({bus.rd, bus.md_en, bus.pc_out} !== {5'd3, 1'b0, 32'h204}) begin
      n_fail++; $display("[TB] FAIL %s_held_add: got rd=%0d md=%b pc=%h want 3 0 204", name, bus.rd, bus.md_en, bus.pc_out);
    end
    step();
  endtask

  task automatic test_decode_table();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.instr    = dec_instr[i];
      step();
      bus.in_valid = 1'b0;
      n_checks++; if ({bus.illegal, bus.alu_op, bus.ext_op, bus.npc_op} !== dec_exp[i]) begin
        n_fail++; $display("[TB] FAIL decode_%0d: got %b want %b", i, {bus.illegal, bus.alu_op, bus.ext_op, bus.npc_op}, dec_exp[i]);
      end
      step();
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.instr    = ill_instr[i];
      step();
      bus.in_valid = 1'b0;
      n_checks++; if ({bus.out_valid, bus.illegal, bus.rf_we, bus.dm_we, bus.dm_re, bus.npc_op, bus.md_en} !== 9'b1_1_0_0_0_000_0) begin
        n_fail++; $display("[TB] FAIL illegal_%0d: got v=%b ill=%b we=%b dwe=%b dre=%b npc=%b md=%b want 1 1 0 0 0 000 0",
                           i, bus.out_valid, bus.illegal, bus.rf_we, bus.dm_we, bus.dm_re, bus.npc_op, bus.md_en);
      end
      step();
    end
  endtask

  task automatic test_no_m();
    bus_n.out_ready = 1'b1;
    bus_n.in_valid  = 1'b1;
    bus_n.instr     = I_MUL;
    step();
    bus_n.instr = I_BAD;
    #1;
    n_checks++; if ({bus_n.out_valid, bus_n.illegal, bus_n.rf_we, bus_n.md_en} !== 4'b1100) begin
      n_fail++; $display("[TB] FAIL nom_mul: got v=%b ill=%b we=%b md=%b want 1 1 0 0", bus_n.out_valid, bus_n.illegal, bus_n.rf_we, bus_n.md_en);
    end
    step();
    bus_n.in_valid = 1'b0;
    n_checks++; if ({bus_n.out_valid, bus_n.illegal, bus_n.rf_we} !== 3'b110) begin
      n_fail++; $display("[TB] FAIL nom_opcode: got v=%b ill=%b we=%b want 1 1 0", bus_n.out_valid, bus_n.illegal, bus_n.rf_we);
    end
    step();
    n_checks++; if (bus_n.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL nom_drain: got %b want 0", bus_n.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = I_JAL;
    step();
    n_checks++; if ({bus.out_valid, bus.npc_op, bus.rf_wsrc, bus.ext_op} !== {1'b1, 3'b010, 2'b10, 6'b000001}) begin
      n_fail++; $display("[TB] FAIL flush_jal: got v=%b npc=%b wsrc=%b ext=%b want 1 010 10 000001", bus.out_valid, bus.npc_op, bus.rf_wsrc, bus.ext_op);
    end
    bus.flush = 1'b1;
    bus.instr = I_ADD;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_drop: got %b want 0", bus.out_valid); end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_stay: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_busy();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = I_DIV;
    bus.pc_in     = 32'h400;
    step();
    bus.instr = I_ADD;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    n_checks++; if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL rbusy_busy: got v=%b rdy=%b want 0 0", bus.out_valid, bus.in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({bus.out_valid, bus.in_ready, bus.pc_out, bus.rd, bus.alu_op, bus.rf_we} !== {1'b0, 1'b1, 32'h0, 5'd0, 5'd0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL rbusy_async: got v=%b rdy=%b pc=%h rd=%0d alu=%b we=%b want 0 1 0 0 00000 0",
                         bus.out_valid, bus.in_ready, bus.pc_out, bus.rd, bus.alu_op, bus.rf_we);
    end
    step();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr    = I_SUB;
    step();
    bus.in_valid = 1'b0;
    n_checks++; if ({bus.out_valid, bus.alu_op} !== {1'b1, 5'b01000}) begin
      n_fail++; $display("[TB] FAIL rbusy_idle: got v=%b alu=%b want 1 01000", bus.out_valid, bus.alu_op);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.instr       = 32'h0;
    bus.pc_in       = 32'h0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
    bus_n.in_valid  = 1'b0;
    bus_n.instr     = 32'h0;
    bus_n.pc_in     = 32'h0;
    bus_n.flush     = 1'b0;
    bus_n.out_ready = 1'b1;

    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_md_latency(I_DIV, 33, "div");
    test_md_latency(I_MUL, 4, "mul");
    test_decode_table();
    test_illegal();
    test_no_m();
    test_flush();
    test_reset_busy();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
